// File: rtl/decoder_stage_controller.sv
// rtl/decoder_stage_controller.sv - grow/merge stage sequencer for a PE array decoder (optional DECODE_CYCLE_COUNTER_EN)
module decoder_stage_controller #(
    parameter int PU_COUNT         = 64,
    parameter int MIN_MERGE_CYCLES = 3,
    parameter int MAX_ITERATIONS   = 16,
    parameter int ITER_WIDTH       = 5,
    localparam int STAGE_WIDTH     = 3,
    localparam logic [STAGE_WIDTH-1:0] STAGE_IDLE                = 3'd0,
    localparam logic [STAGE_WIDTH-1:0] STAGE_MEASUREMENT_LOADING = 3'd1,
    localparam logic [STAGE_WIDTH-1:0] STAGE_GROW                = 3'd2,
    localparam logic [STAGE_WIDTH-1:0] STAGE_MERGE               = 3'd3,
    localparam logic [STAGE_WIDTH-1:0] STAGE_RESULT_VALID        = 3'd4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [PU_COUNT-1:0]    busy_vector,
    input  logic [PU_COUNT-1:0]    odd_vector,
    output logic [STAGE_WIDTH-1:0] global_stage,
    output logic                   controller_busy,
    output logic                   result_valid,
    output logic [ITER_WIDTH-1:0]  iteration_count,
    output logic                   timeout_error,
    output logic [31:0]            cycle_count
);

    localparam int MC_W = (MIN_MERGE_CYCLES < 1) ? 1 : $clog2(MIN_MERGE_CYCLES + 1);
    localparam logic [MC_W-1:0] MC_MAX  = MC_W'(MIN_MERGE_CYCLES);
    localparam logic [MC_W-1:0] MC_EXIT = MC_W'((MIN_MERGE_CYCLES < 1) ? 0 : MIN_MERGE_CYCLES - 1);
    localparam logic [ITER_WIDTH-1:0] ITER_LIMIT = ITER_WIDTH'(MAX_ITERATIONS);

    typedef enum logic [STAGE_WIDTH-1:0] {
        S_IDLE         = STAGE_IDLE,
        S_LOAD         = STAGE_MEASUREMENT_LOADING,
        S_GROW         = STAGE_GROW,
        S_MERGE        = STAGE_MERGE,
        S_RESULT_VALID = STAGE_RESULT_VALID
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [MC_W-1:0]   merge_counter;
    logic              any_busy;
    logic              any_odd;
    logic              merge_done;
    logic              accept;

    assign any_busy   = |busy_vector;
    assign any_odd    = |odd_vector;
    assign merge_done = (state == S_MERGE) && (merge_counter >= MC_EXIT) && !any_busy;
    assign accept     = (state == S_IDLE) && start;

    assign global_stage    = state;
    assign controller_busy = (state != S_IDLE);
    assign result_valid    = (state == S_RESULT_VALID);

    // Stage register; the broadcast stage comes straight from here.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-stage selection: merge first after loading, grow while defects remain and budget allows.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:         if (start) next_state = S_LOAD;
            S_LOAD:         next_state = S_MERGE;
            S_GROW:         next_state = S_MERGE;
            S_MERGE: begin
                if (merge_done) begin
                    if (any_odd && (iteration_count < ITER_LIMIT)) begin
                        next_state = S_GROW;
                    end else begin
                        next_state = S_RESULT_VALID;
                    end
                end
            end
            S_RESULT_VALID: next_state = S_IDLE;
            default:        next_state = S_IDLE;
        endcase
    end

    // Merge dwell counter, iteration count and timeout flag.
    always_ff @(posedge clk) begin
        if (!reset) begin
            merge_counter   <= '0;
            iteration_count <= '0;
            timeout_error   <= 1'b0;
        end else begin
            if (next_state == S_MERGE && state != S_MERGE) begin
                merge_counter <= '0;
            end else if (state == S_MERGE && merge_counter < MC_MAX) begin
                merge_counter <= merge_counter + 1'b1;
            end

            if (accept) begin
                iteration_count <= '0;
                timeout_error   <= 1'b0;
            end else if (next_state == S_GROW) begin
                iteration_count <= iteration_count + 1'b1;
            end

            // Leaving MERGE for the result with defects still present means the budget ran out.
            if (state == S_MERGE && next_state == S_RESULT_VALID) begin
                timeout_error <= any_odd;
            end
        end
    end

`ifdef DECODE_CYCLE_COUNTER_EN
    logic [31:0] cycle_reg;

    // Decode latency: cleared on accept, counts non-idle cycles, saturates.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cycle_reg <= '0;
        end else if (state == S_IDLE) begin
            if (start) cycle_reg <= '0;
        end else if (cycle_reg != 32'hFFFF_FFFF) begin
            cycle_reg <= cycle_reg + 32'd1;
        end
    end

    assign cycle_count = cycle_reg;
`else
    assign cycle_count = 32'd0;
`endif

endmodule

// File: tb/tb_decoder_stage_controller.sv
// tb/tb_decoder_stage_controller.sv - self-checking bench for decoder_stage_controller
module tb_decoder_stage_controller;

    localparam int PU   = 8;
    localparam int MINM = 3;
    localparam int MAXI = 2;
    localparam int IW   = 5;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_GROW  = 3'd2;
    localparam logic [2:0] ST_MERGE = 3'd3;
    localparam logic [2:0] ST_RV    = 3'd4;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [PU-1:0] busy_vector;
    logic [PU-1:0] odd_vector;
    logic [2:0]    global_stage;
    logic          controller_busy;
    logic          result_valid;
    logic [IW-1:0] iteration_count;
    logic          timeout_error;
    logic [31:0]   cycle_count;

    int checks = 0;
    int errors = 0;

    decoder_stage_controller #(
        .PU_COUNT(PU),
        .MIN_MERGE_CYCLES(MINM),
        .MAX_ITERATIONS(MAXI),
        .ITER_WIDTH(IW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .busy_vector(busy_vector),
        .odd_vector(odd_vector),
        .global_stage(global_stage),
        .controller_busy(controller_busy),
        .result_valid(result_valid),
        .iteration_count(iteration_count),
        .timeout_error(timeout_error),
        .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic longint exp_cc(input int n);
`ifdef DECODE_CYCLE_COUNTER_EN
        return n;
`else
        return 0;
`endif
    endfunction

    function automatic logic [PU-1:0] rnd();
        return PU'($urandom);
    endfunction

    function automatic logic [PU-1:0] nz();
        logic [PU-1:0] v;
        v = PU'($urandom);
        v[$urandom_range(PU-1, 0)] = 1'b1;
        return v;
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_stage"}, global_stage, ST_IDLE);
        chk({tag, "_cbusy"}, controller_busy, 0);
        chk({tag, "_rv"}, result_valid, 0);
        chk({tag, "_iter"}, iteration_count, 0);
        chk({tag, "_tout"}, timeout_error, 0);
        chk({tag, "_cc"}, cycle_count, 0);
    endtask

    // Plan one decode as a list of merges, derive the expected stage trace, then play it.
    // Caller is at a negedge with the DUT idle.
    task automatic run_decode(input int n_odd, input int b0, input int b1, input int b2,
                              input bit hold, output int ncyc, output int iters, output bit tout);
        logic [2:0]    exp_q[$];
        logic [PU-1:0] bq[$];
        logic [PU-1:0] oq[$];
        int blen[3];
        int merges;
        int len;
        blen[0] = b0; blen[1] = b1; blen[2] = b2;
        if (n_odd > MAXI) begin
            merges = MAXI + 1; iters = MAXI; tout = 1'b1;
        end else begin
            merges = n_odd + 1; iters = n_odd; tout = 1'b0;
        end
        exp_q.push_back(ST_LOAD); bq.push_back(rnd()); oq.push_back(rnd());
        for (int m = 0; m < merges; m++) begin
            len = (blen[m] + 1 > MINM) ? blen[m] + 1 : MINM;
            for (int c = 0; c < len; c++) begin
                exp_q.push_back(ST_MERGE);
                bq.push_back((c < blen[m]) ? nz() : '0);
                oq.push_back((c == len - 1) ? ((m < n_odd) ? nz() : '0) : rnd());
            end
            if (m < merges - 1) begin
                exp_q.push_back(ST_GROW); bq.push_back(rnd()); oq.push_back(rnd());
            end
        end
        exp_q.push_back(ST_RV); bq.push_back(rnd()); oq.push_back(rnd());
        ncyc = exp_q.size();

        start = 1'b1; busy_vector = rnd(); odd_vector = rnd();
        for (int k = 0; k < ncyc; k++) begin
            @(negedge clk);
            chk("trace_stage", global_stage, exp_q[k]);
            chk("trace_rv", result_valid, (exp_q[k] == ST_RV) ? 1 : 0);
            chk("trace_cbusy", controller_busy, 1);
            start       = hold ? 1'b1 : 1'(($urandom % 2));
            busy_vector = bq[k];
            odd_vector  = oq[k];
        end
        @(negedge clk);
        chk("end_stage", global_stage, ST_IDLE);
        chk("end_cbusy", controller_busy, 0);
        chk("end_rv", result_valid, 0);
        chk("end_iter", iteration_count, iters);
        chk("end_tout", timeout_error, tout);
        chk("end_cc", cycle_count, exp_cc(ncyc));
        start = hold ? 1'b1 : 1'b0;
    endtask

    typedef struct {
        int n_odd;
        int b0;
        int b1;
        int b2;
        int exp_cycles;
        int exp_iter;
        bit exp_to;
    } vec_t;

    vec_t tbl[5];

    initial begin
        int ncyc;
        int iters;
        bit tout;

        tbl[0] = '{0, 0, 0, 0, 5, 0, 1'b0};
        tbl[1] = '{1, 4, 0, 0, 11, 1, 1'b0};
        tbl[2] = '{5, 0, 0, 0, 13, 2, 1'b1};
        tbl[3] = '{2, 2, 0, 7, 18, 2, 1'b0};
        tbl[4] = '{0, 9, 0, 0, 12, 0, 1'b0};

        // Reset state, with start asserted during reset
        reset = 1'b0; start = 1'b1; busy_vector = '0; odd_vector = '1;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        reset = 1'b1; start = 1'b0;
        @(negedge clk);
        chk("reset_release_stage", global_stage, ST_IDLE);

        // Directed table
        for (int i = 0; i < 5; i++) begin
            run_decode(tbl[i].n_odd, tbl[i].b0, tbl[i].b1, tbl[i].b2, 1'b0, ncyc, iters, tout);
            chk("tbl_cycles", ncyc, tbl[i].exp_cycles);
            chk("tbl_iter", iters, tbl[i].exp_iter);
            chk("tbl_tout", tout, tbl[i].exp_to);
        end

        // start held high: back-to-back decodes separated by one IDLE cycle
        run_decode(0, 0, 0, 0, 1'b1, ncyc, iters, tout);
        run_decode(1, 1, 2, 0, 1'b1, ncyc, iters, tout);
        start = 1'b0;
        @(negedge clk);
        chk("hold_idle", global_stage, ST_IDLE);

        // Randomized decodes against the plan model
        for (int r = 0; r < 40; r++) begin
            run_decode($urandom_range(3, 0), $urandom_range(5, 0), $urandom_range(5, 0),
                       $urandom_range(5, 0), 1'b0, ncyc, iters, tout);
            repeat ($urandom_range(2, 0)) begin
                @(negedge clk);
                chk("gap_stage", global_stage, ST_IDLE);
                chk("gap_iter", iteration_count, iters);
            end
        end

        // Reset during the second MERGE aborts with no result
        start = 1'b1; busy_vector = '0; odd_vector = '1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        chk("abort_pre_stage", global_stage, ST_MERGE);
        chk("abort_pre_iter", iteration_count, 1);
        reset = 1'b0; start = 1'b1;
        @(negedge clk);
        chk_all_zero("abort");
        @(negedge clk);
        chk_all_zero("abort_hold");
        reset = 1'b1; start = 1'b0;
        @(negedge clk);
        chk("abort_after_stage", global_stage, ST_IDLE);
        chk("abort_after_rv", result_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
